// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue (with package alu_iq_pkg)
// Brief    : Collapsing, age-ordered out-of-order issue buffer for the integer
//            ALU. Holds renamed micro-ops until every source operand has been
//            captured from the snooped register-file write ports, then issues
//            the oldest ready op as a registered rob_issue packet whenever the
//            ALU signals ready.
// Revision : 1.0 - initial release
// ============================================================================

package alu_iq_pkg;
  localparam int c_PHYS_W = 7;
  localparam int c_UOP_W  = 8;
  localparam int c_XLEN   = 64;

  typedef struct packed {
    logic                valid;
    logic [c_UOP_W-1:0]  uop;
    logic [c_PHYS_W-1:0] dest_reg_phys;
    logic [c_XLEN-1:0]   r0_val;
    logic [c_XLEN-1:0]   r1_val;
    logic [c_XLEN-1:0]   r2_val;
  } rob_issue;

  typedef struct packed {
    logic                en;
    logic [c_PHYS_W-1:0] index_in;
    logic [c_XLEN-1:0]   data_in;
  } RegFileWritePort;
endpackage

// PHYS_W must equal c_PHYS_W: tags are compared directly with index_in.
module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PHYS_W = c_PHYS_W,
  parameter int NWB    = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_N_in,
  input  logic                         flush_in,
  input  logic                         enq_valid_in,
  output logic                         enq_ready_out,
  input  rob_issue                     enq_insn_in,
  input  logic [2:0][PHYS_W-1:0]       enq_src_tag_in,
  input  logic [2:0]                   enq_src_rdy_in,
  input  RegFileWritePort [NWB-1:0]    wb_in,
  input  logic                         alu_ready_in,
  output rob_issue                     issue_out,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_out
);

  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [c_UOP_W-1:0]     uop;
    logic [PHYS_W-1:0]      dest;
    logic [2:0][PHYS_W-1:0] tag;
    logic [2:0]             rdy;
    logic [2:0][c_XLEN-1:0] val;
  } entry_t;

  entry_t [DEPTH-1:0] r_ent;
  entry_t [DEPTH-1:0] w_nxt;
  entry_t             w_new;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic [c_CNT_W-1:0] w_enq_slot;
  logic [DEPTH-1:0]   w_cand;
  logic               w_sel_found;
  logic [c_IDX_W-1:0] w_sel_idx;
  logic               w_enq;
  logic               w_issue;
  rob_issue           r_issue;
  rob_issue           w_issue_pkt;
  logic               w_unused;

  // Capture any matching writeback into not-yet-ready operands; the lowest
  // port index wins because it is evaluated last.
  function automatic entry_t f_wake(input entry_t e, input RegFileWritePort [NWB-1:0] wb);
    entry_t r;
    r = e;
    for (int op = 0; op < 3; op++) begin
      if (!e.rdy[op]) begin
        for (int k = NWB - 1; k >= 0; k--) begin
          if (wb[k].en && (wb[k].index_in == e.tag[op])) begin
            r.rdy[op] = 1'b1;
            r.val[op] = wb[k].data_in;
          end
        end
      end
    end
    return r;
  endfunction

  // The incoming valid bit carries no information for the queue.
  assign w_unused = enq_insn_in.valid;

  assign enq_ready_out = (r_count < c_CNT_W'(DEPTH));
  assign w_enq         = enq_valid_in & enq_ready_out & ~flush_in;
  assign w_issue       = alu_ready_in & w_sel_found;
  assign w_enq_slot    = r_count - c_CNT_W'(w_issue);
  assign w_count_nxt   = r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_issue);

  assign w_new = '{
    uop:  enq_insn_in.uop,
    dest: enq_insn_in.dest_reg_phys,
    tag:  enq_src_tag_in,
    rdy:  enq_src_rdy_in,
    val:  {enq_insn_in.r2_val, enq_insn_in.r1_val, enq_insn_in.r0_val}
  };

  // Per-slot candidate flags from registered ready bits, and next-state
  // contents: collapse above the issued slot, apply wakeup, insert new op.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    entry_t w_src;
    assign w_cand[i] = (r_count > c_CNT_W'(i)) & (&r_ent[i].rdy);
    if (i < DEPTH - 1) begin : g_shift
      assign w_src = (w_issue && (w_sel_idx <= c_IDX_W'(i))) ? r_ent[i+1] : r_ent[i];
    end else begin : g_top
      assign w_src = r_ent[i];
    end
    assign w_nxt[i] = (w_enq && (w_enq_slot == c_CNT_W'(i))) ? f_wake(w_new, wb_in)
                                                             : f_wake(w_src, wb_in);
  end

  // Oldest-first select: lowest valid slot with all three operands ready.
  always_comb begin
    w_sel_found = |w_cand;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_cand[i]) w_sel_idx = c_IDX_W'(i);
    end
  end

  // Build the outgoing packet; all-zero whenever nothing issues.
  always_comb begin
    w_issue_pkt = '0;
    if (w_issue) begin
      w_issue_pkt.valid         = 1'b1;
      w_issue_pkt.uop           = r_ent[w_sel_idx].uop;
      w_issue_pkt.dest_reg_phys = r_ent[w_sel_idx].dest;
      w_issue_pkt.r0_val        = r_ent[w_sel_idx].val[0];
      w_issue_pkt.r1_val        = r_ent[w_sel_idx].val[1];
      w_issue_pkt.r2_val        = r_ent[w_sel_idx].val[2];
    end
  end

  // State update; flush squashes everything and overrides enqueue/issue.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_count <= '0;
      r_issue <= '0;
      r_ent   <= '0;
    end else if (flush_in) begin
      r_count <= '0;
      r_issue <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_issue <= w_issue_pkt;
      r_ent   <= w_nxt;
    end
  end

  assign issue_out     = r_issue;
  assign occupancy_out = r_count;

endmodule
`default_nettype wire
